mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multi-cycle sequencer for the MIPS datapath. It shares one memory port, one ALU and one register file across the phases of each instruction. A Moore-style FSM steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and waits on a memory ready handshake. It decodes the supported R/I/J subset from the instruction register (IR) and drives every datapath mux and enable. It flags unsupported encodings and halts on them.

Parameters:
ALU_OP_W, 4, width of alu_op
STATE_W, 4, width of state encoding / debug port

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
op  input  6  IR[31:26], stable from the cycle after FETCH completes
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, combinational
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC load enable
pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target {PC[31:28],IR[25:0],2'b00}
ir_write  output  1  IR load enable
mem_addr_src  output  1  0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write enable
reg_dst  output  1  1 rd, 0 rt
mem_to_reg  output  1  1 MDR, 0 ALUOut
alu_src_a  output  2  00 PC, 01 rs, 10 zero-extended shamt
alu_src_b  output  2  00 rt, 01 constant 4, 10 extended imm, 11 extended imm<<2
sign_ext  output  1  1 sign-extend imm16, 0 zero-extend
alu_op  output  ALU_OP_W  0000 ADD, 0001 ADDU, 0010 SUB, 0011 SUBU, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000 SLT, 1001 SLTU, 1010 SLL, 1011 SRL, 1100 SRA
instr_done  output  1  one-cycle pulse in the last cycle of each instruction
illegal  output  1  sticky unsupported-encoding flag
state  output  STATE_W  current state, for debug

Behaviour:
- Single clock; reset is synchronous and active-high: rst=1 at a rising clk edge sets state=FETCH and clears illegal. While rst=1, every enable (pc_write, ir_write, mem_read, mem_write, reg_write, instr_done) is forced 0. Mux selects and alu_op are 0.
- Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12. Encodings 13-15 go to FETCH.
- FETCH:
  - Drives mem_read=1, mem_addr_src=0, alu_src_a=00, alu_src_b=01, alu_op=ADD, pc_src=00.
  - When mem_ready=1, pulses ir_write=1 and pc_write=1, then goes to DECODE; otherwise it holds with no writes.
- DECODE:
  - Drives alu_src_a=00, alu_src_b=11, sign_ext=1, alu_op=ADD, so the branch target is latched in ALUOut.
  - Next state by op/funct:
    - lw/sw → MEM_ADDR
    - R-type → R_EXEC
    - beq/bne → BRANCH
    - j → JUMP
    - addi/addiu/ori/xori → I_EXEC
    - anything else → TRAP
  - Supported R-type funct values: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav. op=0 with any other funct → TRAP.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, sign_ext=1, alu_op=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, mem_addr_src=1; waits for mem_ready, then goes to MEM_WB.
- MEM_WR: mem_write=1, mem_addr_src=1; on mem_ready pulses instr_done and goes to FETCH. mem_write stays asserted until mem_ready.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 → FETCH.
- R_EXEC:
  - Shift-immediate (sll/srl/sra): alu_src_a=10. Variable shifts: alu_src_a=01. Others: alu_src_a=01. alu_src_b=00 in all cases.
  - alu_op per funct: sllv→SLL, srlv→SRL, srav→SRA; other functs map directly to the same-named code.
  - Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 → FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=SUB, pc_src=01. pc_write = beq ? zero : ~zero. instr_done=1 → FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 → FETCH.
- I_EXEC:
  - alu_src_a=01, alu_src_b=10.
  - sign_ext=1 for addi/addiu, 0 for ori/xori.
  - alu_op: ADD for addi, ADDU for addiu, OR for ori, XOR for xori.
  - Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 → FETCH.
- TRAP: illegal=1 (registered, set on entry); all enables 0; held until rst.
- Latency with mem_ready=1 in every memory cycle: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j 3. Each memory wait cycle adds one cycle.
- Outputs decode combinationally from state (plus op/funct/zero/mem_ready where noted); state is registered only.

Test Plan:
- Reset: assert rst for 2 cycles while mem_ready=1 → state=0, pc_write=ir_write=mem_read=0, illegal=0. The first cycle after release has mem_read=1.
- add (op=000000, funct=100000), mem_ready=1 → states 0,1,6,7. alu_op=0000 in R_EXEC. reg_write=1, reg_dst=1 and instr_done=1 in cycle 4.
- lw (op=100011) with mem_ready low for 3 cycles in MEM_RD → 8 cycles total. mem_addr_src=1 and no reg_write until MEM_WB, then mem_to_reg=1.
- beq (op=000100) with zero=1 → pc_write=1 and pc_src=01 in BRANCH. bne (op=000101) with zero=1 → pc_write=0 while instr_done still pulses.
- ori (op=001101) → sign_ext=0 and alu_op=0101 in I_EXEC. sra (funct=000011) → alu_src_a=10, alu_op=1100.
- op=111111 → TRAP, illegal=1 persists for 10+ cycles with no enables. rst then returns the FSM to FETCH; rst asserted in MEM_WR also aborts the write, with mem_write=0 from the next cycle.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: a registered-state Moore FSM whose datapath
// selects and enables are decoded combinationally from state, op/funct, zero and mem_ready.
module mc_control_unit #(
    parameter int ALU_OP_W = 4,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                ir_write,
    output logic                mem_addr_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                sign_ext,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t     cur_state;
    state_t     decode_next;
    logic       illegal_q;
    logic [3:0] alu_code;

    function automatic logic r_funct_ok(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU: r_funct_ok = 1'b1;
            default:                          r_funct_ok = 1'b0;
        endcase
    endfunction

    // Variable shifts reuse the immediate-shift ALU codes; only operand A differs.
    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            FN_ADDU:          r_alu = ALU_ADDU;
            FN_SUB:           r_alu = ALU_SUB;
            FN_SUBU:          r_alu = ALU_SUBU;
            FN_AND:           r_alu = ALU_AND;
            FN_OR:            r_alu = ALU_OR;
            FN_XOR:           r_alu = ALU_XOR;
            FN_NOR:           r_alu = ALU_NOR;
            FN_SLT:           r_alu = ALU_SLT;
            FN_SLTU:          r_alu = ALU_SLTU;
            FN_SLL, FN_SLLV:  r_alu = ALU_SLL;
            FN_SRL, FN_SRLV:  r_alu = ALU_SRL;
            FN_SRA, FN_SRAV:  r_alu = ALU_SRA;
            default:          r_alu = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        decode_next = S_TRAP;
        case (op)
            OP_RTYPE:                            decode_next = r_funct_ok(funct) ? S_R_EXEC : S_TRAP;
            OP_LW, OP_SW:                        decode_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                      decode_next = S_BRANCH;
            OP_J:                                decode_next = S_JUMP;
            OP_ADDI, OP_ADDIU, OP_ORI, OP_XORI:  decode_next = S_I_EXEC;
            default:                             decode_next = S_TRAP;
        endcase
    end

    // Memory handshake: mem_read/mem_write are held for the whole access and the
    // access completes in the cycle mem_ready is high; the FSM advances on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH:    if (mem_ready) cur_state <= S_DECODE;
                S_DECODE: begin
                    cur_state <= decode_next;
                    if (decode_next == S_TRAP) illegal_q <= 1'b1;
                end
                S_MEM_ADDR: cur_state <= (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) cur_state <= S_MEM_WB;
                S_MEM_WB:   cur_state <= S_FETCH;
                S_MEM_WR:   if (mem_ready) cur_state <= S_FETCH;
                S_R_EXEC:   cur_state <= S_R_WB;
                S_R_WB:     cur_state <= S_FETCH;
                S_BRANCH:   cur_state <= S_FETCH;
                S_JUMP:     cur_state <= S_FETCH;
                S_I_EXEC:   cur_state <= S_I_WB;
                S_I_WB:     cur_state <= S_FETCH;
                S_TRAP: begin
                    cur_state <= S_TRAP;
                    illegal_q <= 1'b1;
                end
                default:    cur_state <= S_FETCH;
            endcase
        end
    end

    // Everything is held at zero while rst is high so an abandoned instruction
    // cannot issue a write in the reset cycle.
    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        mem_addr_src = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        sign_ext     = 1'b0;
        alu_code     = ALU_ADD;
        instr_done   = 1'b0;
        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    sign_ext  = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    sign_ext  = 1'b1;
                end
                S_MEM_RD: begin
                    mem_read     = 1'b1;
                    mem_addr_src = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write    = 1'b1;
                    mem_addr_src = 1'b1;
                    instr_done   = mem_ready;
                end
                S_R_EXEC: begin
                    alu_src_a = (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
                                ? 2'b10 : 2'b01;
                    alu_code  = r_alu(funct);
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 2'b01;
                    alu_code   = ALU_SUB;
                    pc_src     = 2'b01;
                    pc_write   = (op == OP_BEQ) ? zero : ~zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    sign_ext  = (op == OP_ADDI || op == OP_ADDIU);
                    case (op)
                        OP_ADDIU: alu_code = ALU_ADDU;
                        OP_ORI:   alu_code = ALU_OR;
                        OP_XORI:  alu_code = ALU_XOR;
                        default:  alu_code = ALU_ADD;
                    endcase
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_op  = ALU_OP_W'(alu_code);
    assign state   = STATE_W'(cur_state);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference model expands each
// instruction into per-cycle expectations and a latency; monitors compare them.
module tb_mc_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_addr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] a;
        logic [1:0] b;
        logic       sign_ext;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } obs_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BR = 3, K_J = 4, K_I = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, mem_addr_src, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, sign_ext, instr_done, illegal;
    logic [1:0] pc_src, alu_src_a, alu_src_b;
    logic [3:0] alu_op, state;

    logic [49:0] exp_q[$];
    int          lat_q[$];
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    logic        m_illegal = 1'b0;
    obs_t        ev, em;

    always #5 clk = ~clk;

    mc_control_unit #(.ALU_OP_W(4), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_addr_src(mem_addr_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .sign_ext(sign_ext), .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    // ---------------- reference model ----------------
    function automatic int klass(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:                      klass = (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                                 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                                 6'h26, 6'h27, 6'h2a, 6'h2b}) ? K_R : K_ILL;
            6'h23:                      klass = K_LW;
            6'h2b:                      klass = K_SW;
            6'h04, 6'h05:               klass = K_BR;
            6'h02:                      klass = K_J;
            6'h08, 6'h09, 6'h0d, 6'h0e: klass = K_I;
            default:                    klass = K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] r_alu_ref(input logic [5:0] f);
        case (f)
            6'h20: r_alu_ref = 4'd0;   6'h21: r_alu_ref = 4'd1;
            6'h22: r_alu_ref = 4'd2;   6'h23: r_alu_ref = 4'd3;
            6'h24: r_alu_ref = 4'd4;   6'h25: r_alu_ref = 4'd5;
            6'h26: r_alu_ref = 4'd6;   6'h27: r_alu_ref = 4'd7;
            6'h2a: r_alu_ref = 4'd8;   6'h2b: r_alu_ref = 4'd9;
            6'h00, 6'h04: r_alu_ref = 4'd10;
            6'h02, 6'h06: r_alu_ref = 4'd11;
            default:      r_alu_ref = 4'd12;
        endcase
    endfunction

    function automatic int latency(input int k, input int fw, input int mw);
        case (k)
            K_LW:      latency = 5 + fw + mw;
            K_SW:      latency = 4 + fw + mw;
            K_BR, K_J: latency = 3 + fw;
            default:   latency = 4 + fw;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic begin_exp(input logic [3:0] st);
        ev = '0; em = '0;
        ev.st = st; em.st = '1;
        em.pc_write = 1; em.ir_write = 1; em.mem_read = 1; em.mem_write = 1;
        em.reg_write = 1; em.instr_done = 1;
        ev.illegal = m_illegal; em.illegal = 1;
    endtask

    task automatic set_a(input logic [1:0] x);      ev.a = x;            em.a = '1;            endtask
    task automatic set_b(input logic [1:0] x);      ev.b = x;            em.b = '1;            endtask
    task automatic set_alu(input logic [3:0] x);    ev.alu_op = x;       em.alu_op = '1;       endtask
    task automatic set_pcsrc(input logic [1:0] x);  ev.pc_src = x;       em.pc_src = '1;       endtask
    task automatic set_sext(input logic x);         ev.sign_ext = x;     em.sign_ext = 1;      endtask
    task automatic set_mas(input logic x);          ev.mem_addr_src = x; em.mem_addr_src = 1;  endtask
    task automatic set_wb(input logic rd, input logic m2r);
        ev.reg_write = 1; ev.instr_done = 1;
        ev.reg_dst = rd; em.reg_dst = 1;
        ev.mem_to_reg = m2r; em.mem_to_reg = 1;
    endtask

    task automatic step(input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        exp_q.push_back({em, ev});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        m_illegal = 1'b0;
        for (int i = 0; i < n; i++) begin
            ev = '0; em = '1;
            if (i == 0) begin
                em.st = '0;
                em.illegal = 1'b0;
            end
            rst = 1'b1;
            step(1'b1, 1'($urandom));
        end
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                             input int mw, input logic z, input bit abort);
        int k;
        k = klass(o, f);
        if (!abort && k != K_ILL) lat_q.push_back(latency(k, fw, mw));
        for (int w = 0; w <= fw; w++) begin
            logic r;
            r = (w == fw);
            begin_exp(4'd0);
            ev.mem_read = 1; set_mas(0); set_a(2'b00); set_b(2'b01); set_alu(4'd0); set_pcsrc(2'b00);
            ev.ir_write = r; ev.pc_write = r;
            op = 6'($urandom);
            funct = 6'($urandom);
            step(r, 1'($urandom));
        end
        op = o;
        funct = f;
        begin_exp(4'd1);
        set_a(2'b00); set_b(2'b11); set_sext(1); set_alu(4'd0);
        step(1'($urandom), 1'($urandom));
        case (k)
            K_LW, K_SW: begin
                begin_exp(4'd2);
                set_a(2'b01); set_b(2'b10); set_sext(1); set_alu(4'd0);
                step(1'($urandom), 1'($urandom));
                if (k == K_LW) begin
                    for (int w = 0; w <= mw; w++) begin
                        begin_exp(4'd3);
                        ev.mem_read = 1; set_mas(1);
                        step(w == mw, 1'($urandom));
                    end
                    begin_exp(4'd4);
                    set_wb(1'b0, 1'b1);
                    step(1'($urandom), 1'($urandom));
                end else begin
                    for (int w = 0; w < (abort ? mw : mw + 1); w++) begin
                        logic r;
                        r = !abort && (w == mw);
                        begin_exp(4'd5);
                        ev.mem_write = 1; set_mas(1); ev.instr_done = r;
                        step(r, 1'($urandom));
                    end
                end
            end
            K_R: begin
                begin_exp(4'd6);
                set_a((f == 6'h00 || f == 6'h02 || f == 6'h03) ? 2'b10 : 2'b01);
                set_b(2'b00); set_alu(r_alu_ref(f));
                step(1'($urandom), 1'($urandom));
                begin_exp(4'd7);
                set_wb(1'b1, 1'b0);
                step(1'($urandom), 1'($urandom));
            end
            K_BR: begin
                begin_exp(4'd8);
                set_a(2'b01); set_b(2'b00); set_alu(4'd2); set_pcsrc(2'b01);
                ev.pc_write = (o == 6'h04) ? z : !z;
                ev.instr_done = 1;
                step(1'($urandom), z);
            end
            K_J: begin
                begin_exp(4'd9);
                set_pcsrc(2'b10); ev.pc_write = 1; ev.instr_done = 1;
                step(1'($urandom), 1'($urandom));
            end
            K_I: begin
                begin_exp(4'd10);
                set_a(2'b01); set_b(2'b10);
                set_sext(o == 6'h08 || o == 6'h09);
                set_alu(o == 6'h08 ? 4'd0 : o == 6'h09 ? 4'd1 : o == 6'h0d ? 4'd5 : 4'd6);
                step(1'($urandom), 1'($urandom));
                begin_exp(4'd11);
                set_wb(1'b0, 1'b0);
                step(1'($urandom), 1'($urandom));
            end
            default: begin
                m_illegal = 1'b1;
                for (int i = 0; i < 12; i++) begin
                    begin_exp(4'd12);
                    step(1'($urandom), 1'($urandom));
                end
            end
        endcase
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        obs_t        o;
        logic [49:0] e;
        logic [24:0] ob, v, m;
        int          want;
        o.st = state; o.pc_write = pc_write; o.pc_src = pc_src; o.ir_write = ir_write;
        o.mem_addr_src = mem_addr_src; o.mem_read = mem_read; o.mem_write = mem_write;
        o.reg_write = reg_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
        o.a = alu_src_a; o.b = alu_src_b; o.sign_ext = sign_ext; o.alu_op = alu_op;
        o.instr_done = instr_done; o.illegal = illegal;
        ob = o;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = e[49:25];
            v = e[24:0];
            tests++;
            if (((ob ^ v) & m) != '0) begin
                failed++;
                $display("FAIL outputs t=%0t state=%0d got=%h exp=%h care=%h",
                         $time, state, ob & m, v & m, m);
            end
        end
        if (rst) begin
            cyc = 0;
        end else begin
            cyc++;
            if (instr_done) begin
                tests++;
                if (lat_q.size() == 0) begin
                    failed++;
                    $display("FAIL latency t=%0t got unexpected instr_done required none", $time);
                end else begin
                    want = lat_q.pop_front();
                    if (cyc != want) begin
                        failed++;
                        $display("FAIL latency t=%0t got=%0d required=%0d", $time, cyc, want);
                    end
                end
                cyc = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops [12];
        logic [5:0] rfn [16];
        logic [5:0] o, f;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h09, 6'h0d, 6'h0e};
        rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
        rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(6'h00, 6'h20, 0, 0, 1'b0, 0);   // add
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 0);   // lw, 3 wait cycles
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, 0);   // beq taken
        run_instr(6'h05, 6'h00, 0, 0, 1'b1, 0);   // bne not taken
        run_instr(6'h0d, 6'h00, 1, 0, 1'b0, 0);   // ori
        run_instr(6'h00, 6'h03, 0, 0, 1'b0, 0);   // sra
        run_instr(6'h2b, 6'h00, 2, 2, 1'b0, 0);   // sw
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, 0);   // j

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 11)];
            f = (o == 6'h00) ? rfn[$urandom_range(0, 15)] : 6'($urandom);
            run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 0);
        end

        run_instr(6'h3f, 6'h00, 0, 0, 1'b0, 0);   // illegal opcode
        do_reset(2);
        run_instr(6'h00, 6'h01, 1, 0, 1'b0, 0);   // R-type with unsupported funct
        do_reset(1);
        run_instr(6'h2b, 6'h00, 0, 2, 1'b0, 1);   // sw abandoned by reset
        do_reset(2);
        run_instr(6'h08, 6'h00, 0, 0, 1'b0, 0);   // addi after recovery

        tests++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            failed++;
            $display("FAIL drain got exp_q=%0d lat_q=%0d required 0 0", exp_q.size(), lat_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
